// File: rtl/wishbone_to_axi4lite_pkg.sv
// rtl/wishbone_to_axi4lite_pkg.sv - shared AXI4-Lite response codes and bridge state encoding
//
// Purpose: response codes and FSM state type for the Wishbone-to-AXI4-Lite bridge.
// Ports:   none (package).

package wishbone_to_axi4lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR    = 3'd1,
      ST_WRESP = 3'd2,
      ST_RD    = 3'd3,
      ST_RDATA = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   // SLVERR/DECERR complete with wb_err, OKAY/EXOKAY with wb_ack.
   function automatic logic resp_is_err(input logic [1:0] resp);
      logic err;
      case (resp)
         RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
         RESP_SLVERR, RESP_DECERR: err = 1'b1;
         default:                  err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/wishbone_to_axi4lite.sv
// rtl/wishbone_to_axi4lite.sv - Wishbone classic slave to AXI4-Lite master bridge
//
// Purpose: turns single Wishbone reads/writes into AXI4-Lite transactions, one
//          outstanding at a time; the AXI response maps onto wb_ack_o / wb_err_o.
// Ports:   clk_i, rst_i (sync, active-high)
//          wb_*     Wishbone classic slave side; wb_dat_o holds the last read data
//          axi_aw*, axi_w*, axi_b*   AXI4-Lite write channels (master)
//          axi_ar*, axi_r*           AXI4-Lite read channels (master)
//          All outputs are registered.

module wishbone_to_axi4lite
   import wishbone_to_axi4lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
   input  logic                    wb_we_i,
   input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,
   output logic [ADDR_WIDTH-1:0]   axi_awaddr_o,
   output logic                    axi_awvalid_o,
   input  logic                    axi_awready_i,
   output logic [DATA_WIDTH-1:0]   axi_wdata_o,
   output logic [DATA_WIDTH/8-1:0] axi_wstrb_o,
   output logic                    axi_wvalid_o,
   input  logic                    axi_wready_i,
   input  logic [1:0]              axi_bresp_i,
   input  logic                    axi_bvalid_i,
   output logic                    axi_bready_o,
   output logic [ADDR_WIDTH-1:0]   axi_araddr_o,
   output logic                    axi_arvalid_o,
   input  logic                    axi_arready_i,
   input  logic [DATA_WIDTH-1:0]   axi_rdata_i,
   input  logic [1:0]              axi_rresp_i,
   input  logic                    axi_rvalid_i,
   output logic                    axi_rready_o
);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic arvalid_q, arvalid_d, rready_q, rready_d;
   logic aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic aborted_q, aborted_d;
   logic ack_q, ack_d, err_q, err_d;
   logic aw_hs, w_hs, notify;

   assign aw_hs = awvalid_q & axi_awready_i;
   assign w_hs  = wvalid_q & axi_wready_i;
   // Completion is reported only if the master held cyc for the whole transaction.
   assign notify = wb_cyc_i & ~aborted_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      aborted_d = aborted_q | ((state_q != ST_IDLE) & ~wb_cyc_i);
      ack_d     = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            aborted_d = 1'b0;
            if (wb_cyc_i && wb_stb_i) begin
               addr_d  = wb_adr_i;
               wdata_d = wb_dat_i;
               wstrb_d = wb_sel_i;
               if (wb_we_i) begin
                  state_d   = ST_WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = ST_RD;
                  arvalid_d = 1'b1;
               end
            end
         end
         ST_WR: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
               state_d  = ST_WRESP;
               bready_d = 1'b1;
            end
         end
         ST_WRESP: begin
            if (axi_bvalid_i) begin
               bready_d = 1'b0;
               state_d  = ST_DONE;
               ack_d    = notify & ~resp_is_err(axi_bresp_i);
               err_d    = notify &  resp_is_err(axi_bresp_i);
            end
         end
         ST_RD: begin
            if (axi_arready_i) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RDATA;
            end
         end
         ST_RDATA: begin
            if (axi_rvalid_i) begin
               rready_d = 1'b0;
               rdata_d  = axi_rdata_i;
               state_d  = ST_DONE;
               ack_d    = notify & ~resp_is_err(axi_rresp_i);
               err_d    = notify &  resp_is_err(axi_rresp_i);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         aborted_q <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         aborted_q <= aborted_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   assign wb_dat_o      = rdata_q;
   assign wb_ack_o      = ack_q;
   assign wb_err_o      = err_q;
   assign axi_awaddr_o  = addr_q;
   assign axi_araddr_o  = addr_q;
   assign axi_wdata_o   = wdata_q;
   assign axi_wstrb_o   = wstrb_q;
   assign axi_awvalid_o = awvalid_q;
   assign axi_wvalid_o  = wvalid_q;
   assign axi_bready_o  = bready_q;
   assign axi_arvalid_o = arvalid_q;
   assign axi_rready_o  = rready_q;

endmodule

// File: tb/tb_wishbone_to_axi4lite.sv
// tb/tb_wishbone_to_axi4lite.sv - directed self-checking bench for wishbone_to_axi4lite

module tb_wishbone_to_axi4lite;

   logic        clk, rst;
   logic        wb_cyc, wb_stb, wb_we;
   logic [31:0] wb_adr, wb_dat_in, wb_dat_out;
   logic [3:0]  wb_sel;
   logic        wb_ack, wb_err;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   wishbone_to_axi4lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_adr_i(wb_adr), .wb_we_i(wb_we),
      .wb_sel_i(wb_sel), .wb_dat_i(wb_dat_in), .wb_dat_o(wb_dat_out),
      .wb_ack_o(wb_ack), .wb_err_o(wb_err),
      .axi_awaddr_o(awaddr), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
      .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wvalid_o(wvalid), .axi_wready_i(wready),
      .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
      .axi_araddr_o(araddr), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
      .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rvalid_i(rvalid), .axi_rready_o(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Slave knobs: *_dly = cycles of valid/ready seen before the slave answers.
   int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
   logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
   logic [31:0] rdata_v = 32'h0;
   int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;

   always @(negedge clk) begin
      if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
      else begin awready = 1'b0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
      else begin wready = 1'b0; w_cnt = 0; end
      if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
      else begin arready = 1'b0; ar_cnt = 0; end
      if (bready) begin bvalid = (b_cnt >= b_dly); b_cnt++; end
      else begin bvalid = 1'b0; b_cnt = 0; end
      if (rready) begin rvalid = (r_cnt >= r_dly); r_cnt++; end
      else begin rvalid = 1'b0; r_cnt = 0; end
      bresp = bresp_v;
      rresp = rresp_v;
      rdata = rvalid ? rdata_v : 32'hBAD0_BAD0;
   end

   // Observations from the last transaction; cycle 1 is the first cycle after
   // the edge that samples the strobe.
   int ack_c, err_c, awv_n, wv_n, br_n, ar_n, rr_first;
   logic lookahead;
   logic [31:0] snap_awaddr, snap_araddr, snap_wdata;
   logic [3:0]  snap_wstrb;

   task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int abort_at, input bit keep);
      ack_c = -1; err_c = -1; awv_n = 0; wv_n = 0; br_n = 0; ar_n = 0;
      rr_first = -1; lookahead = 1'b0;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_in = dat; wb_sel = sel;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 1) begin
            snap_awaddr = awaddr; snap_araddr = araddr;
            snap_wdata = wdata;   snap_wstrb = wstrb;
         end
         if (awvalid) awv_n++;
         if (wvalid)  wv_n++;
         if (bready)  br_n++;
         if (arvalid) ar_n++;
         if (rready && rr_first < 0) rr_first = n;
         if ((bready && (awvalid || wvalid)) || (rready && arvalid)) lookahead = 1'b1;
         if (wb_ack && ack_c < 0) ack_c = n;
         if (wb_err && err_c < 0) err_c = n;
         if (n == abort_at) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
         if (wb_ack || wb_err) break;
      end
      if (!keep) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
   endtask

   initial begin
      rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      wb_adr = '0; wb_dat_in = '0; wb_sel = '0;
      repeat (3) @(negedge clk);
      chk("rst_ctl", {awvalid, wvalid, bready, arvalid, rready, wb_ack, wb_err}, 7'b0);
      chk("rst_dat", {wb_dat_out, awaddr, wdata, wstrb}, '0);
      rst = 1'b0;
      @(negedge clk);

      // Zero-wait write
      txn(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 0, 1'b0);
      chk("w0_ack", ack_c, 3);
      chk("w0_err", err_c, -1);
      chk("w0_awn", awv_n, 1);
      chk("w0_wn", wv_n, 1);
      chk("w0_addr", snap_awaddr, 32'h40);
      chk("w0_data", snap_wdata, 32'hDEADBEEF);
      chk("w0_strb", snap_wstrb, 4'hF);
      @(negedge clk);

      // Skewed channels: awvalid held 4 cycles, W handshakes in cycle 1
      aw_dly = 3;
      txn(1'b1, 32'h44, 32'h0000A5A5, 4'h3, 0, 1'b0);
      chk("ws_awn", awv_n, 4);
      chk("ws_wn", wv_n, 1);
      chk("ws_ack", ack_c, 6);
      chk("ws_strb", snap_wstrb, 4'h3);
      chk("ws_look", lookahead, 1'b0);
      aw_dly = 0;
      @(negedge clk);

      // Read with arready wait and SLVERR
      ar_dly = 1; rresp_v = 2'b10; rdata_v = 32'h12345678;
      txn(1'b0, 32'h80, 32'h0, 4'hF, 0, 1'b0);
      chk("re_err", err_c, 4);
      chk("re_ack", ack_c, -1);
      chk("re_dat", wb_dat_out, 32'h12345678);
      chk("re_arn", ar_n, 2);
      chk("re_rr1", rr_first, 3);
      chk("re_addr", snap_araddr, 32'h80);
      chk("re_look", lookahead, 1'b0);
      ar_dly = 0; rresp_v = 2'b00;
      @(negedge clk);

      // Abort: cyc dropped in WRESP; bready stays until bvalid, no completion
      b_dly = 3;
      txn(1'b1, 32'h48, 32'h11112222, 4'hF, 2, 1'b0);
      chk("ab_ack", ack_c, -1);
      chk("ab_err", err_c, -1);
      chk("ab_brn", br_n, 4);
      chk("ab_sticky", wb_dat_out, 32'h12345678);
      b_dly = 0;
      rdata_v = 32'hCAFEF00D;
      txn(1'b0, 32'h84, 32'h0, 4'hF, 0, 1'b0);
      chk("ab_rd_ack", ack_c, 3);
      chk("ab_rd_dat", wb_dat_out, 32'hCAFEF00D);
      @(negedge clk);

      // Reset while waiting in RDATA
      r_dly = 10;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h88;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      chk("rs_rready", rready, 1'b1);
      rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rs_ctl", {awvalid, wvalid, bready, arvalid, rready, wb_ack, wb_err}, 7'b0);
      chk("rs_dat", wb_dat_out, 32'h0);
      rst = 1'b0; r_dly = 0;
      @(negedge clk);
      txn(1'b1, 32'h4C, 32'h55AA55AA, 4'hC, 0, 1'b0);
      chk("rs_w_ack", ack_c, 3);
      chk("rs_w_strb", snap_wstrb, 4'hC);
      @(negedge clk);

      // Back-to-back: DECERR write, then read requested in the err cycle
      bresp_v = 2'b11; rresp_v = 2'b01; rdata_v = 32'h0BADF00D;
      txn(1'b1, 32'h50, 32'h01020304, 4'hF, 0, 1'b1);
      chk("bb_err", err_c, 3);
      chk("bb_wack", ack_c, -1);
      txn(1'b0, 32'h90, 32'h0, 4'hF, 0, 1'b0);
      chk("bb_rack", ack_c, 4);
      chk("bb_rdat", wb_dat_out, 32'h0BADF00D);
      chk("bb_addr", araddr, 32'h90);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
